// File: rtl/scv_pkg.sv
// Shared constants and types for the two-phase CPU clock generator.
// Default divider, strobe phase positions, the VDC clock-enable mask and
// the stall state encoding live here so the top, its decoder and any
// neighbouring blocks agree on one set of numbers.
package scv_pkg;

    // Period minus one after reset (CLK/14).
    localparam int CLKGEN_DEF_DIV_M1 = 13;

    // Counts at which the four CPU phase strobes fire.
    localparam int CLKGEN_P_CP2N = 0;
    localparam int CLKGEN_P_CP1P = 2;
    localparam int CLKGEN_P_CP1N = 4;
    localparam int CLKGEN_P_CP2P = 6;

    // VDC clock-enable: high at counts 2 and 9 of a 16-slot mask.
    localparam logic [15:0] CLKGEN_VDC_CE_MASK = 16'h0204;

    // Stall state machine: RUN lets the CPU strobes through, STALLED
    // freezes them with CP2 logically held high.
    typedef enum logic [0:0] {
        CLKGEN_RUN     = 1'b0,
        CLKGEN_STALLED = 1'b1
    } clkgen_stall_t;

    // Largest of four phase positions; the divider never goes below this
    // so every strobe is reachable in every period.
    function automatic int clkgen_max4(input int a, input int b,
                                       input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/clkgen_phase_if.sv
// Bus between the clock generator and its consumer (CPU core / system glue).
//
// Stall handshake: STALL_REQ is a level held by the requester. It is only
// sampled at period wrap, so a pulse that starts and ends between two wraps
// is never seen. STALL_ACK is high while the CPU phases are frozen; it rises
// at count 0 of the first frozen period and falls at count 0 of the first
// released period, in the same cycle as the resuming CP2_NEGEDGE. The
// requester must keep STALL_REQ high until it has seen STALL_ACK if it needs
// the stall, and may drop it at any time to request release.
interface clkgen_phase_if
    import scv_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int NUM_CE = 1
);
    logic [CNT_W-1:0]  DIV_M1;
    logic              STALL_REQ;
    logic              STALL_ACK;
    logic              CP1_POSEDGE;
    logic              CP1_NEGEDGE;
    logic              CP2_POSEDGE;
    logic              CP2_NEGEDGE;
    logic [NUM_CE-1:0] CE;
    logic [CNT_W-1:0]  PHASE;
    logic [31:0]       CYC_CNT;
    clkgen_stall_t     stall_state;   // debug view of the stall FSM

    // Consumer side: requests divider and stall, observes strobes.
    modport master (
        output DIV_M1, STALL_REQ,
        input  STALL_ACK, CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE,
        input  CE, PHASE, CYC_CNT, stall_state
    );

    // Clock generator side.
    modport slave (
        input  DIV_M1, STALL_REQ,
        output STALL_ACK, CP1_POSEDGE, CP1_NEGEDGE, CP2_POSEDGE, CP2_NEGEDGE,
        output CE, PHASE, CYC_CNT, stall_state
    );

endinterface

// File: rtl/clkgen_ce_decode.sv
// One auxiliary clock-enable channel: a per-count lookup into a fixed mask.
// The enable ignores the CPU stall, so peripherals such as the VDC keep
// their cadence while the CPU is frozen.
module clkgen_ce_decode #(
    parameter int                    CNT_W = 4,
    parameter logic [(2**CNT_W)-1:0] MASK  = '0
) (
    input  logic             run,
    input  logic [CNT_W-1:0] ccnt,
    output logic             ce
);

    // Enable is the mask bit for the current count, gated by run.
    always_comb begin
        ce = run & MASK[ccnt];
    end

endmodule

// File: rtl/clkgen_phase.sv
// Parametrised two-phase clock generator for the uPD7800 core.
// One master-clock phase counter produces the four CPU phase strobes and
// NUM_CE auxiliary clock-enables. The divide ratio is taken from DIV_M1 only
// at period wrap, and a level-sensitive stall freezes the CPU strobes (CP2
// held high) while the auxiliary enables keep running.
// Optional build macro CLKGEN_PHASE_CYCCNT_EN adds a 32-bit CPU cycle counter
// on CYC_CNT; without it CYC_CNT is constant zero.
module clkgen_phase
    import scv_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int DEF_DIV_M1 = CLKGEN_DEF_DIV_M1,
    parameter int P_CP2N     = CLKGEN_P_CP2N,
    parameter int P_CP1P     = CLKGEN_P_CP1P,
    parameter int P_CP1N     = CLKGEN_P_CP1N,
    parameter int P_CP2P     = CLKGEN_P_CP2P,
    parameter int NUM_CE     = 1,
    parameter logic [NUM_CE*(2**CNT_W)-1:0] CE_MASKS = CLKGEN_VDC_CE_MASK
) (
    input  logic CLK,
    input  logic RESB,
    clkgen_phase_if.slave bus
);

    localparam int               PERIOD_MAX = 2**CNT_W;
    localparam int               MIN_DIV_M1 = clkgen_max4(P_CP2N, P_CP1P, P_CP1N, P_CP2P);
    localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_DIV_M1);
    localparam logic [CNT_W-1:0] DEF_C      = CNT_W'(DEF_DIV_M1);
    localparam logic [CNT_W-1:0] P_CP2N_C   = CNT_W'(P_CP2N);
    localparam logic [CNT_W-1:0] P_CP1P_C   = CNT_W'(P_CP1P);
    localparam logic [CNT_W-1:0] P_CP1N_C   = CNT_W'(P_CP1N);
    localparam logic [CNT_W-1:0] P_CP2P_C   = CNT_W'(P_CP2P);

    logic             run;
    logic [CNT_W-1:0] ccnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_next;
    clkgen_stall_t    stall_q;
    logic             cpu_en;
    logic             wrap;
    logic             cp2n;
    logic             cp1p;
    logic             cp1n;
    logic             cp2p;
    logic [NUM_CE-1:0] ce_w;

    assign cpu_en   = (stall_q == CLKGEN_RUN);
    assign wrap     = (ccnt == div_q);
    // Requests shorter than the last strobe position are clamped up.
    assign div_next = (bus.DIV_M1 < MIN_C) ? MIN_C : bus.DIV_M1;

    // Phase counter and divider shadow: count 0..div_q, reload divider at wrap.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            run   <= 1'b0;
            ccnt  <= '0;
            div_q <= DEF_C;
        end else if (!run) begin
            run  <= 1'b1;
            ccnt <= '0;
        end else if (ccnt > div_q) begin
            // Unreachable in normal operation; recover rather than run away.
            ccnt <= '0;
        end else if (wrap) begin
            ccnt  <= '0;
            div_q <= div_next;
        end else begin
            ccnt <= ccnt + CNT_W'(1);
        end
    end

    // Stall FSM: only moves on a wrap edge, so CPU periods are never cut short.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            stall_q <= CLKGEN_RUN;
        end else if (run && wrap) begin
            case (stall_q)
                CLKGEN_RUN:     if (bus.STALL_REQ)  stall_q <= CLKGEN_STALLED;
                CLKGEN_STALLED: if (!bus.STALL_REQ) stall_q <= CLKGEN_RUN;
                default:        stall_q <= CLKGEN_RUN;
            endcase
        end
    end

    // CPU strobes: one CLK wide, decoded from registered counter and state.
    always_comb begin
        cp2n = run & cpu_en & (ccnt == P_CP2N_C);
        cp1p = run & cpu_en & (ccnt == P_CP1P_C);
        cp1n = run & cpu_en & (ccnt == P_CP1N_C);
        cp2p = run & cpu_en & (ccnt == P_CP2P_C);
    end

    for (genvar i = 0; i < NUM_CE; i++) begin : g_ce
        clkgen_ce_decode #(
            .CNT_W (CNT_W),
            .MASK  (CE_MASKS[i*PERIOD_MAX +: PERIOD_MAX])
        ) u_ce_decode (
            .run  (run),
            .ccnt (ccnt),
            .ce   (ce_w[i])
        );
    end

    assign bus.CP2_NEGEDGE = cp2n;
    assign bus.CP1_POSEDGE = cp1p;
    assign bus.CP1_NEGEDGE = cp1n;
    assign bus.CP2_POSEDGE = cp2p;
    assign bus.CE          = ce_w;
    assign bus.STALL_ACK   = run & ~cpu_en;
    assign bus.PHASE       = ccnt;
    assign bus.stall_state = stall_q;

`ifdef CLKGEN_PHASE_CYCCNT_EN
    logic [31:0] cyc_q;

    // CPU cycle counter: one count per emitted CP2_NEGEDGE, wraps naturally.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            cyc_q <= '0;
        end else if (cp2n) begin
            cyc_q <= cyc_q + 32'd1;
        end
    end

    assign bus.CYC_CNT = cyc_q;
`else
    assign bus.CYC_CNT = '0;
`endif

endmodule

// File: tb/tb_clkgen_phase.sv
// Directed bench for clkgen_phase with default parameters (CLK/14, strobes
// at 0/2/4/6, VDC enable at 2 and 9).
module tb_clkgen_phase;
    import scv_pkg::*;

    logic clk  = 1'b0;
    logic resb = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    // Expected {phase, ack, cp2n, cp1p, cp1n, cp2p, ce0} words.
    logic [9:0] exp_q[$];

    clkgen_phase_if #(.CNT_W(4), .NUM_CE(1)) bus ();

    clkgen_phase #(.CNT_W(4), .NUM_CE(1)) dut (
        .CLK  (clk),
        .RESB (resb),
        .bus  (bus)
    );

    // Clock: 10 time units per CLK.
    always #5 clk = ~clk;

    // Observed {ack, cp2n, cp1p, cp1n, cp2p, ce0}.
    function automatic logic [5:0] obs_vec();
        return {bus.STALL_ACK, bus.CP2_NEGEDGE, bus.CP1_POSEDGE,
                bus.CP1_NEGEDGE, bus.CP2_POSEDGE, bus.CE[0]};
    endfunction

    // Expected outputs at count c with the CPU running (cpu_on) or stalled.
    function automatic logic [5:0] exp_vec(input int c, input bit cpu_on);
        return {!cpu_on, cpu_on && c == 0, cpu_on && c == 2,
                cpu_on && c == 4, cpu_on && c == 6, c == 2 || c == 9};
    endfunction

    task automatic test_reset();
        resb          = 1'b0;
        bus.DIV_M1    = 4'd13;
        bus.STALL_REQ = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({obs_vec(), bus.PHASE, bus.CYC_CNT} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: vec=%b phase=%0d cyc=%0d want all 0",
                     obs_vec(), bus.PHASE, bus.CYC_CNT);
        end
        resb = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.PHASE !== 4'd0 || obs_vec() !== exp_vec(0, 1'b1)) begin
            failures++;
            $display("FAIL startup_first_cycle: phase=%0d vec=%b want phase=0 vec=%b",
                     bus.PHASE, obs_vec(), exp_vec(0, 1'b1));
        end
    endtask

    // Two full CLK/14 periods from count 0, via the expected queue.
    task automatic test_default_period();
        logic [9:0] got;
        logic [9:0] want;
        for (int k = 1; k <= 28; k++)
            exp_q.push_back({4'(k % 14), exp_vec(k % 14, 1'b1)});
        while (exp_q.size() > 0) begin
            @(negedge clk);
            want = exp_q.pop_front();
            got  = {bus.PHASE, obs_vec()};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL default_period: got phase=%0d vec=%b want phase=%0d vec=%b",
                         got[9:6], got[5:0], want[9:6], want[5:0]);
            end
        end
    endtask

    // 13 -> 6 requested at count 3: current period still 14, then 7.
    task automatic test_div_change();
        int c;
        for (int k = 1; k <= 28; k++) begin
            if (k <= 13) c = k;
            else c = (k - 14) % 7;
            @(negedge clk);
            checks++;
            if (bus.PHASE !== 4'(c) || obs_vec() !== exp_vec(c, 1'b1)) begin
                failures++;
                $display("FAIL div_change k=%0d: phase=%0d vec=%b want phase=%0d vec=%b",
                         k, bus.PHASE, obs_vec(), c, exp_vec(c, 1'b1));
            end
            if (k == 3) bus.DIV_M1 = 4'd6;
        end
    endtask

    // DIV_M1=3 is below the last strobe position and must clamp to 7 CLK.
    task automatic test_div_clamp();
        int c;
        bus.DIV_M1 = 4'd3;
        for (int k = 1; k <= 21; k++) begin
            c = k % 7;
            @(negedge clk);
            checks++;
            if (bus.PHASE !== 4'(c) || obs_vec() !== exp_vec(c, 1'b1)) begin
                failures++;
                $display("FAIL div_clamp k=%0d: phase=%0d vec=%b want phase=%0d vec=%b",
                         k, bus.PHASE, obs_vec(), c, exp_vec(c, 1'b1));
            end
        end
    endtask

    // Back to 14, then a stall raised at 5, held 3 periods, dropped at 8.
    task automatic test_stall();
        int  c;
        bit  on;
        bus.DIV_M1 = 4'd13;
        for (int k = 1; k <= 7 + 14 + 42 + 14; k++) begin
            if (k <= 6) c = k;
            else c = (k - 7) % 14;
            // k=7..20 running period, 21..62 stalled, 63.. running again
            on = (k < 21) || (k >= 63);
            @(negedge clk);
            checks++;
            if (bus.PHASE !== 4'(c) || obs_vec() !== exp_vec(c, on)) begin
                failures++;
                $display("FAIL stall k=%0d: phase=%0d vec=%b want phase=%0d vec=%b",
                         k, bus.PHASE, obs_vec(), c, exp_vec(c, on));
            end
            if (k == 30) begin
                checks++;
                if (bus.stall_state !== CLKGEN_STALLED) begin
                    failures++;
                    $display("FAIL stall_state: got %0d want %0d",
                             bus.stall_state, CLKGEN_STALLED);
                end
            end
            if (k == 12) bus.STALL_REQ = 1'b1;            // count 5
            if (k == 7 + 28 + 14 + 8) bus.STALL_REQ = 1'b0; // count 8, 3rd stalled period
        end
    endtask

    // A request pulse wholly between two wraps must be ignored.
    task automatic test_stall_pulse();
        int c;
        for (int k = 1; k <= 28; k++) begin
            c = k % 14;
            @(negedge clk);
            checks++;
            if (bus.PHASE !== 4'(c) || obs_vec() !== exp_vec(c, 1'b1)) begin
                failures++;
                $display("FAIL stall_pulse k=%0d: phase=%0d vec=%b want phase=%0d vec=%b",
                         k, bus.PHASE, obs_vec(), c, exp_vec(c, 1'b1));
            end
            if (k == 3) bus.STALL_REQ = 1'b1;
            if (k == 9) bus.STALL_REQ = 1'b0;
        end
    endtask

    // Reset asserted at count 7 of a stalled period, DIV_M1 changed meanwhile.
    task automatic test_reset_mid_stall();
        int c;
        bus.STALL_REQ = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            c = k % 14;
            @(negedge clk);
            checks++;
            if (bus.PHASE !== 4'(c) || obs_vec() !== exp_vec(c, k < 14)) begin
                failures++;
                $display("FAIL pre_reset_stall k=%0d: phase=%0d vec=%b want phase=%0d vec=%b",
                         k, bus.PHASE, obs_vec(), c, exp_vec(c, k < 14));
            end
        end
        bus.DIV_M1    = 4'd6;
        bus.STALL_REQ = 1'b0;
        resb          = 1'b0;
        #1;
        checks++;
        if ({obs_vec(), bus.PHASE, bus.CYC_CNT} !== '0) begin
            failures++;
            $display("FAIL async_reset: vec=%b phase=%0d cyc=%0d want all 0",
                     obs_vec(), bus.PHASE, bus.CYC_CNT);
        end
        @(negedge clk);
        resb = 1'b1;
        // First period after reset uses the default 14, then DIV_M1=6 -> 7.
        for (int k = 0; k <= 21; k++) begin
            if (k <= 13) c = k;
            else c = (k - 14) % 7;
            @(negedge clk);
            checks++;
            if (bus.PHASE !== 4'(c) || obs_vec() !== exp_vec(c, 1'b1)) begin
                failures++;
                $display("FAIL post_reset k=%0d: phase=%0d vec=%b want phase=%0d vec=%b",
                         k, bus.PHASE, obs_vec(), c, exp_vec(c, 1'b1));
            end
        end
    endtask

    // 10 running periods, 3 stalled, then check the CPU cycle count.
    task automatic test_cyc_cnt();
        int          c;
        bit          on;
        logic [31:0] want;
        resb          = 1'b0;
        bus.DIV_M1    = 4'd13;
        bus.STALL_REQ = 1'b0;
        @(negedge clk);
        resb = 1'b1;
        for (int t = 0; t <= 182; t++) begin
            c  = t % 14;
            on = (t < 140) || (t >= 182);
            @(negedge clk);
            checks++;
            if (bus.PHASE !== 4'(c) || obs_vec() !== exp_vec(c, on)) begin
                failures++;
                $display("FAIL cyc_run t=%0d: phase=%0d vec=%b want phase=%0d vec=%b",
                         t, bus.PHASE, obs_vec(), c, exp_vec(c, on));
            end
            if (t == 14 || t == 139 || t == 160 || t == 182) begin
`ifdef CLKGEN_PHASE_CYCCNT_EN
                want = (t == 14) ? 32'd1 : 32'd10;
`else
                want = 32'd0;
`endif
                checks++;
                if (bus.CYC_CNT !== want) begin
                    failures++;
                    $display("FAIL cyc_cnt t=%0d: got %0d want %0d", t, bus.CYC_CNT, want);
                end
            end
            if (t == 131) bus.STALL_REQ = 1'b1;
            if (t == 170) bus.STALL_REQ = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_default_period();
        test_div_change();
        test_div_clamp();
        test_stall();
        test_stall_pulse();
        test_reset_mid_stall();
        test_cyc_cnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
